pipe_shifter: RTL and testbench
===============================

Name: pipe_shifter

Overview:
- Parametrised, pipelined logarithmic barrel shifter; generalises the single-mode combinational arithmetic right shifter to a width-N unit.
- Supports SLL/SRL/SRA and, optionally, rotates.
- Valid/ready handshake on input and output, one result per cycle at full throughput, per-operation tag passed through.
- Sits between the ALU issue logic and writeback for multi-cycle shift ops.

Parameters:
- N, 32, data width; power of two, >= 4.
- TAG_W, 4, width of opaque tag carried alongside each operation.
- LOG (localparam), $clog2(N), number of shift stages; equals the number of pipeline registers.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept this cycle.
- in_data  input  N  value to shift.
- in_shamt  input  LOG  shift amount, 0..N-1.
- in_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 ROR (see Optional Feature).
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  N  shifted result.
- out_tag  output  TAG_W  tag of the presented result.

Behaviour:
- Reset:
  - While rst_n=0, all stage valid bits clear immediately (asynchronous), so out_valid=0 and in_ready=1.
  - out_data and out_tag reset to 0.
  - Reset mid-operation discards all in-flight ops with no output.
- Stage k (k=0..LOG-1) conditionally shifts by 2^k when shamt bit k=1, then registers data, remaining shamt bits, op, tag and valid bit v[k].
- Stage ordering is LSB first. Results must be identical for any shamt regardless of ordering.
- Fill bits per op:
  - SLL: zeros in from the LSB.
  - SRL: zeros in from the MSB.
  - SRA: copies of the original in_data[N-1] in from the MSB. The sign bit is captured at stage 0 and carried, not re-read from intermediate data.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- Shift of 0: out_data equals in_data for every op.
- Handshake and flow control:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - Stage advance: adv[LOG-1] = !v[LOG-1] || out_ready; adv[k] = !v[k] || adv[k+1].
  - in_ready = adv[0], combinational from out_ready through the valid chain.
  - Stage k register loads when adv[k]. v[k] takes the upstream valid (in_valid for k=0).
  - Bubbles collapse: an empty stage accepts even when downstream stalls.
- Latency: an op accepted at edge E is presented on out_* after edge E+LOG-1, i.e. LOG edges including E; 5 for N=32. Throughput 1/cycle with out_ready held high.
- Capacity: LOG ops in flight. With out_ready=0 the pipeline fills, then in_ready=0.
- Ordering: results leave strictly in acceptance order. No op is dropped or duplicated.
- Stability: out_data/out_tag hold stable while out_valid && !out_ready.
- in_data, in_shamt, in_op and in_tag are don't-care when in_valid=0. Invalid stages must not change the output registers' visible value while out_valid=0 is irrelevant to consumers.
- Simultaneous events: on the same edge with a full pipeline and out_ready=1, one result leaves and one op enters. in_ready is 1 that cycle.

Optional Feature:
- Macro: PIPE_SHIFTER_ROTATE_EN.
- Defined: op 10 performs ROR as above. A rotate-left by s is issued by software as ROR by (N-s) mod N.
- Undefined:
  - Op 10 is decoded as SRL.
  - No rotate wraparound muxing is synthesised.
  - All other behaviour is identical.

Test Plan:
- Basic ops (N=32): SRA 0x80000000 shamt 31 -> 0xFFFFFFFF; SRL same -> 0x00000001; SLL 0x00000001 shamt 31 -> 0x80000000; SRA 0x7FFFFFF0 shamt 4 -> 0x07FFFFFF.
- Zero shift and throughput: 64 back-to-back random ops with shamt=0 included, out_ready=1 -> first result after 5 edges, then one result/cycle. Data matches the golden model and tags appear in order.
- Backpressure: out_ready=0, offer 8 ops with tags 0..7 -> exactly 5 accepted, then in_ready=0. Raise out_ready -> tags 0..7 emerge in order, out_data held stable during the stall.
- Bubble collapse: single op enters, out_ready=0 -> op advances to the last stage. A second op offered 2 cycles later is accepted and advances until it sits behind the first.
- Reset mid-flight: 3 ops in flight, drop rst_n between edges -> out_valid=0 immediately, in_ready=1. After release, no stale results appear.
- Rotate (PIPE_SHIFTER_ROTATE_EN): ROR 0x00000001 shamt 1 -> 0x80000000; ROR 0x12345678 shamt 8 -> 0x78123456. Without the macro, op 10 on 0x80000000 shamt 31 -> 0x00000001.

Source files
------------

// File: rtl/pipe_shifter.sv
// Pipelined log barrel shifter: SLL/SRL/SRA with valid/ready flow and tag pass-through.
// Define PIPE_SHIFTER_ROTATE_EN to make op 2'b10 a rotate-right; otherwise it is SRL.
module pipe_shifter #(
    parameter  int N     = 32,
    parameter  int TAG_W = 4,
    localparam int LOG   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [LOG-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic [N-1:0]     d_q     [LOG];
    logic [LOG-1:0]   s_q     [LOG];
    logic [1:0]       op_q    [LOG];
    logic [TAG_W-1:0] tag_q   [LOG];
    logic             sgn_q   [LOG];
    logic [LOG-1:0]   v_q;

    logic [N-1:0]     src_d   [LOG];
    logic [LOG-1:0]   src_s   [LOG];
    logic [1:0]       src_op  [LOG];
    logic [TAG_W-1:0] src_tag [LOG];
    logic             src_sgn [LOG];
    logic [LOG-1:0]   src_v;
    logic [N-1:0]     sh_d    [LOG];
    logic [LOG-1:0]   adv;
    logic             chain;

    always_comb begin
        src_d[0]   = in_data;
        src_s[0]   = in_shamt;
        src_op[0]  = in_op;
        src_tag[0] = in_tag;
        src_sgn[0] = in_data[N-1];
        src_v      = '0;
        src_v[0]   = in_valid;
        for (int k = 1; k < LOG; k++) begin
            src_d[k]   = d_q[k-1];
            src_s[k]   = s_q[k-1];
            src_op[k]  = op_q[k-1];
            src_tag[k] = tag_q[k-1];
            src_sgn[k] = sgn_q[k-1];
            src_v[k]   = v_q[k-1];
        end
    end

    // SRA fills from the sign captured at entry, not the partially shifted data.
    always_comb begin
        for (int k = 0; k < LOG; k++) begin
            sh_d[k] = src_d[k];
            if (src_s[k][k]) begin
                unique case (src_op[k])
                    2'b00: sh_d[k] = src_d[k] << (1 << k);
                    2'b11: sh_d[k] = N'($signed({src_sgn[k], src_d[k]}) >>> (1 << k));
`ifdef PIPE_SHIFTER_ROTATE_EN
                    2'b10: sh_d[k] = (src_d[k] >> (1 << k))
                                   | (src_d[k] << (N - (1 << k)));
`endif
                    default: sh_d[k] = src_d[k] >> (1 << k);
                endcase
            end
        end
    end

    // A stage may load when it is empty or its successor moves this cycle.
    always_comb begin
        adv   = '0;
        chain = out_ready;
        for (int k = LOG - 1; k >= 0; k--) begin
            chain  = !v_q[k] || chain;
            adv[k] = chain;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < LOG; k++) begin
                d_q[k]   <= '0;
                s_q[k]   <= '0;
                op_q[k]  <= '0;
                tag_q[k] <= '0;
                sgn_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < LOG; k++) begin
                if (adv[k]) begin
                    v_q[k]   <= src_v[k];
                    d_q[k]   <= sh_d[k];
                    s_q[k]   <= src_s[k];
                    op_q[k]  <= src_op[k];
                    tag_q[k] <= src_tag[k];
                    sgn_q[k] <= src_sgn[k];
                end
            end
        end
    end

    logic unused_tail;
    assign unused_tail = ^{s_q[LOG-1], op_q[LOG-1], sgn_q[LOG-1]};

    assign in_ready  = adv[0];
    assign out_valid = v_q[LOG-1];
    assign out_data  = d_q[LOG-1];
    assign out_tag   = tag_q[LOG-1];

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter: directed vectors, throughput, stalls, reset.
// Reference results come from a whole-word shift model.
module tb_pipe_shifter;
    localparam int N     = 32;
    localparam int TAG_W = 4;
    localparam int LOG   = $clog2(N);

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_data = '0;
    logic [LOG-1:0]   in_shamt = '0;
    logic [1:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    pipe_shifter #(.N(N), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]     data;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_out = 0;
    int stalls = 0;
    bit lat_chk = 1'b0;
    bit done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] d,
                                           input int s, input logic [1:0] op);
        logic [2*N-1:0] ext;
        case (op)
            2'b00: return d << s;
            2'b01: return d >> s;
            2'b11: begin
                ext = {{N{d[N-1]}}, d};
                ext = ext >> s;
                return ext[N-1:0];
            end
            default: begin
`ifdef PIPE_SHIFTER_ROTATE_EN
                return (d >> s) | (d << (N - s));
`else
                return d >> s;
`endif
            end
        endcase
    endfunction

    // Output monitor: every transfer is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            n_out++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got tag %0h data %0h, none expected",
                         out_tag, out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_tag", out_tag, e.tag);
                if (lat_chk)
                    check("latency", cyc - e.acc, LOG - 1);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic offer(input logic [N-1:0] d, input int s,
                         input logic [1:0] op, input logic [TAG_W-1:0] t,
                         input logic [N-1:0] exp);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = LOG'(s);
        in_op    = op;
        in_tag   = t;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{data: exp, tag: t, acc: cyc + 1});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no acceptance for tag %0h, required one", t);
        in_valid = 1'b0;
    endtask

    task automatic rand_offer(input logic [TAG_W-1:0] t, input int sh);
        logic [N-1:0] d;
        int s;
        logic [1:0] op;
        d  = $urandom;
        s  = (sh < 0) ? int'($urandom_range(0, N - 1)) : sh;
        op = 2'($urandom_range(0, 3));
        offer(d, s, op, t, model(d, s, op));
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [TAG_W-1:0] tag_a;
        logic [TAG_W-1:0] tag_b;
        int tg;
        int n_before;

        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with known answers.
        lat_chk = 1'b1;
        offer(32'h80000000, 31, 2'b11, 4'h1, 32'hFFFFFFFF);
        offer(32'h80000000, 31, 2'b01, 4'h2, 32'h00000001);
        offer(32'h00000001, 31, 2'b00, 4'h3, 32'h80000000);
        offer(32'h7FFFFFF0, 4, 2'b11, 4'h4, 32'h07FFFFFF);
        offer(32'h80000001, 0, 2'b11, 4'h5, 32'h80000001);
        offer(32'hA5A5A5A5, 0, 2'b00, 4'h6, 32'hA5A5A5A5);
`ifdef PIPE_SHIFTER_ROTATE_EN
        offer(32'h00000001, 1, 2'b10, 4'h7, 32'h80000000);
        offer(32'h12345678, 8, 2'b10, 4'h8, 32'h78123456);
        offer(32'h12345678, 0, 2'b10, 4'h9, 32'h12345678);
`else
        offer(32'h80000000, 31, 2'b10, 4'h7, 32'h00000001);
        offer(32'h12345678, 8, 2'b10, 4'h8, 32'h00123456);
`endif
        drain();

        // Back-to-back with out_ready high: one op per cycle, fixed latency.
        stalls = 0;
        for (int i = 0; i < 64; i++)
            rand_offer(TAG_W'(i), (i % 8 == 0) ? 0 : -1);
        check("thru_stalls", stalls, 0);
        drain();
        lat_chk = 1'b0;

        // Backpressure: pipeline holds exactly LOG ops.
        out_ready = 1'b0;
        tg = 0;
        for (int i = 0; i < 8; i++) begin
            logic [N-1:0] d;
            int s;
            logic [1:0] op;
            d  = $urandom;
            s  = $urandom_range(0, N - 1);
            op = 2'($urandom_range(0, 3));
            in_valid = 1'b1;
            in_data  = d;
            in_shamt = LOG'(s);
            in_op    = op;
            in_tag   = TAG_W'(tg);
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{data: model(d, s, op), tag: TAG_W'(tg), acc: cyc + 1});
                tg++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", tg, LOG);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_hold_data", out_data, sb[0].data);
            check("bp_hold_tag", out_tag, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int t = tg; t < 8; t++)
            rand_offer(TAG_W'(t), -1);
        drain();

        // Bubble collapse behind a stalled head.
        out_ready = 1'b0;
        tag_a = 4'hA;
        tag_b = 4'hB;
        rand_offer(tag_a, -1);
        repeat (2) @(posedge clk);
        #1;
        stalls = 0;
        rand_offer(tag_b, -1);
        check("bub_b_accept_stalls", stalls, 0);
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        check("bub_head_valid", out_valid, 1);
        check("bub_head_tag", out_tag, tag_a);
        check("bub_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bub_next_valid", out_valid, 1);
        check("bub_next_tag", out_tag, tag_b);
        @(posedge clk);
        #1;
        drain();

        // Reset with ops in flight discards them.
        for (int i = 0; i < 3; i++)
            rand_offer(TAG_W'(i + 12), -1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_tag", out_tag, 0);
        sb.delete();
        n_before = n_out;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("no_stale_outputs", n_out - n_before, 0);

        // Random ops under random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++)
                    rand_offer(TAG_W'(i), -1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    if (!done)
                        out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
